// File: rtl/flash_ctrl_if.sv
// Wishbone classic bus between a master and the flash controller slave.
// Signal names carry the slave-side direction suffix.
interface flash_ctrl_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [21:0] wb_adr_i;
   logic [3:0]  wb_sel_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/flash_ctrl.sv
// Wishbone classic slave driving an asynchronous parallel NOR flash with
// programmable read wait, write setup/pulse/hold and power-up reset timing.
module flash_ctrl #(
   parameter int unsigned RD_WAIT   = 4,
   parameter int unsigned WR_SETUP  = 1,
   parameter int unsigned WR_PULSE  = 3,
   parameter int unsigned WR_HOLD   = 1,
   parameter int unsigned RP_CYCLES = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   flash_ctrl_if.slave      wb,
   output logic [19:0]      fl_addr_o,
   output logic [31:0]      fl_dq_o,
   output logic             fl_dq_oe_o,
   input  logic [31:0]      fl_dq_i,
   output logic             fl_ceb_o,
   output logic             fl_oeb_o,
   output logic             fl_web_o,
   output logic             fl_rpb_o,
   output logic             fl_wpb_o
);

   localparam logic [3:0] RST_HOLD = 4'd0;
   localparam logic [3:0] IDLE     = 4'd1;
   localparam logic [3:0] RD       = 4'd2;
   localparam logic [3:0] RD_ACK   = 4'd3;
   localparam logic [3:0] WR_SU    = 4'd4;
   localparam logic [3:0] WR_PW    = 4'd5;
   localparam logic [3:0] WR_HD    = 4'd6;
   localparam logic [3:0] WR_ACK   = 4'd7;
   localparam logic [3:0] RECOVER  = 4'd8;

   logic [3:0]  state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [7:0]  rp_cnt_q, rp_cnt_d;
   logic        abort_q, abort_d;
   logic        ack_q, ack_d, err_q, err_d;
   logic [31:0] rdat_q, rdat_d;
   logic [19:0] addr_q, addr_d;
   logic [31:0] wdat_q, wdat_d;
   logic        ceb_q, ceb_d, oeb_q, oeb_d, web_q, web_d, oe_q, oe_d, rpb_q, rpb_d;
   logic [3:0]  lim_s;
   logic        wait_done_s, rp_done_s, req_s, live_s;
   logic        unused_s;

   assign unused_s    = ^wb.wb_adr_i[1:0];
   assign req_s       = wb.wb_cyc_i & wb.wb_stb_i;
   // A response is only issued if the master kept the cycle open throughout.
   assign live_s      = wb.wb_cyc_i & ~abort_q;
   assign wait_done_s = (wait_cnt_q == (lim_s - 4'd1));
   assign rp_done_s   = (rp_cnt_q == 8'(RP_CYCLES - 1));

   // Wait-state limit for the current state.
   always_comb begin
      lim_s = 4'd1;
      case (state_q)
         RD:      lim_s = 4'(RD_WAIT);
         WR_SU:   lim_s = 4'(WR_SETUP);
         WR_PW:   lim_s = 4'(WR_PULSE);
         WR_HD:   lim_s = 4'(WR_HOLD);
         default: lim_s = 4'd1;
      endcase
   end

   // Next-state, counters, request latching and registered-output decode.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_done_s ? wait_cnt_q : (wait_cnt_q + 4'd1);
      rp_cnt_d   = ((state_q == RST_HOLD) && !rp_done_s) ? (rp_cnt_q + 8'd1) : 8'd0;
      abort_d    = abort_q;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      rdat_d     = rdat_q;
      addr_d     = addr_q;
      wdat_d     = wdat_q;
      if ((state_q != IDLE) && (state_q != RST_HOLD) && !wb.wb_cyc_i) begin
         abort_d = 1'b1;
      end else begin
         abort_d = abort_q;
      end
      case (state_q)
         RST_HOLD: state_d = rp_done_s ? IDLE : RST_HOLD;
         IDLE: begin
            if (req_s) begin
               addr_d  = wb.wb_adr_i[21:2];
               wdat_d  = wb.wb_dat_i;
               abort_d = 1'b0;
               if (!wb.wb_we_i) begin
                  state_d = RD;
               end else if (wb.wb_sel_i == 4'hF) begin
                  state_d = WR_SU;
               end else begin
                  // Partial-word writes are refused without touching the flash.
                  state_d = WR_ACK;
                  err_d   = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD: begin
            if (wait_done_s) begin
               state_d = RD_ACK;
               ack_d   = live_s;
               rdat_d  = fl_dq_i;
            end else begin
               state_d = RD;
            end
         end
         RD_ACK:  state_d = RECOVER;
         WR_SU:   state_d = wait_done_s ? WR_PW : WR_SU;
         WR_PW:   state_d = wait_done_s ? WR_HD : WR_PW;
         WR_HD: begin
            if (wait_done_s) begin
               state_d = WR_ACK;
               ack_d   = live_s;
            end else begin
               state_d = WR_HD;
            end
         end
         WR_ACK:  state_d = RECOVER;
         RECOVER: state_d = IDLE;
         default: state_d = RECOVER;
      endcase
      if (state_d != state_q) begin
         wait_cnt_d = 4'd0;
      end else begin
         wait_cnt_d = wait_cnt_d;
      end
      ceb_d = !((state_d == RD) || (state_d == WR_SU) || (state_d == WR_PW) || (state_d == WR_HD));
      oeb_d = (state_d != RD);
      web_d = (state_d != WR_PW);
      oe_d  = (state_d == WR_SU) || (state_d == WR_PW) || (state_d == WR_HD);
      rpb_d = (state_d != RST_HOLD);
   end

   // State and output registers; reset forces the flash into its reset hold.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q    <= RST_HOLD;
         wait_cnt_q <= 4'd0;
         rp_cnt_q   <= 8'd0;
         abort_q    <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rdat_q     <= 32'd0;
         addr_q     <= 20'd0;
         wdat_q     <= 32'd0;
         ceb_q      <= 1'b1;
         oeb_q      <= 1'b1;
         web_q      <= 1'b1;
         oe_q       <= 1'b0;
         rpb_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rp_cnt_q   <= rp_cnt_d;
         abort_q    <= abort_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rdat_q     <= rdat_d;
         addr_q     <= addr_d;
         wdat_q     <= wdat_d;
         ceb_q      <= ceb_d;
         oeb_q      <= oeb_d;
         web_q      <= web_d;
         oe_q       <= oe_d;
         rpb_q      <= rpb_d;
      end
   end

   assign wb.wb_dat_o = rdat_q;
   assign wb.wb_ack_o = ack_q;
   assign wb.wb_err_o = err_q;
   assign fl_addr_o   = addr_q;
   assign fl_dq_o     = wdat_q;
   assign fl_dq_oe_o  = oe_q;
   assign fl_ceb_o    = ceb_q;
   assign fl_oeb_o    = oeb_q;
   assign fl_web_o    = web_q;
   assign fl_rpb_o    = rpb_q;
   assign fl_wpb_o    = rpb_q;

endmodule
